// File: rtl/fifo_rd_stream.sv
// Read-side drain controller for the async FIFO: issues r_en under a 2-entry credit limit,
// captures data_read one cycle later and presents it as a packet-framed valid/ready stream.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = 16
) (
    input  logic                  r_clk,
    input  logic                  r_rst_n,
    input  logic                  enable,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] data_read,
    output logic                  r_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [1:0]            level,
    output logic [15:0]           pkt_count
);

    localparam int WCW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

    logic [DATA_WIDTH-1:0] buf_data [2];
    logic [1:0]            buf_last;
    logic [1:0]            cnt;
    logic                  pend;
    logic [WCW-1:0]        word_cnt;
    logic                  pop;
    logic                  cap_last;
    logic [2:0]            credit;

    assign pop      = m_valid & m_ready;
    // Occupancy after this edge if a read were issued now; an in-flight word already holds a slot.
    assign credit   = {1'b0, cnt} + {2'b00, pend} - {2'b00, pop};
    assign r_en     = r_rst_n & enable & ~empty & (credit <= 3'd1);
    assign cap_last = (word_cnt == WCW'(PKT_LEN - 1));

    assign m_valid  = (cnt != 2'd0);
    assign m_data   = buf_data[0];
    assign m_last   = buf_last[0];
    assign level    = cnt;

    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            pend        <= 1'b0;
            cnt         <= 2'd0;
            word_cnt    <= '0;
            pkt_count   <= 16'd0;
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_last    <= 2'b00;
        end else begin
            pend <= r_en;
            if (pend)
                word_cnt <= cap_last ? '0 : word_cnt + 1'b1;
            if (pop && buf_last[0])
                pkt_count <= pkt_count + 16'd1;
            // Entry 0 is always the head; a pop shifts entry 1 forward.
            case ({pend, pop})
                2'b10: begin
                    buf_data[cnt[0]] <= data_read;
                    buf_last[cnt[0]] <= cap_last;
                    cnt              <= cnt + 2'd1;
                end
                2'b01: begin
                    buf_data[0] <= buf_data[1];
                    buf_last[0] <= buf_last[1];
                    cnt         <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        buf_data[0] <= data_read;
                        buf_last[0] <= cap_last;
                    end else begin
                        buf_data[0] <= buf_data[1];
                        buf_last[0] <= buf_last[1];
                        buf_data[1] <= data_read;
                        buf_last[1] <= cap_last;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a queue-based FIFO/stream reference model checked every cycle.
module tb_fifo_rd_stream;

    localparam int DW = 8;
    localparam int PL = 16;

    logic          r_clk = 1'b0;
    logic          r_rst_n;
    logic          enable;
    logic          empty;
    logic [DW-1:0] data_read;
    logic          r_en;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic [1:0]    level;
    logic [15:0]   pkt_count;

    fifo_rd_stream #(.DATA_WIDTH(DW), .PKT_LEN(PL)) dut (
        .r_clk     (r_clk),
        .r_rst_n   (r_rst_n),
        .enable    (enable),
        .empty     (empty),
        .data_read (data_read),
        .r_en      (r_en),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .level     (level),
        .pkt_count (pkt_count)
    );

    always #5 r_clk = ~r_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: words still in the FIFO, words read but not yet delivered.
    logic [DW-1:0] src_q [$];
    logic [DW-1:0] exp_q [$];
    bit            last_q [$];
    bit            inflight = 1'b0;
    logic [DW-1:0] rd_word = '0;
    int            rd_idx = 0;
    int            npop = 0;
    int            pkts = 0;

    int cyc = 0, ren_cnt = 0, ren_run = 0, ren_max = 0;
    int first_ren = -1, first_vld = -1, first_last_pop = -1;

    task automatic clr_stats();
        cyc = 0; ren_cnt = 0; ren_run = 0; ren_max = 0;
        first_ren = -1; first_vld = -1; first_last_pop = -1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        last_q.delete();
        inflight = 1'b0;
        rd_idx   = 0;
        npop     = 0;
        pkts     = 0;
    endtask

    task automatic step(input int rdy_pct, input int stall_pct, input bit en);
        int occ;
        bit pop;
        bit exp_ren;
        @(negedge r_clk);
        data_read = inflight ? rd_word : DW'($urandom);
        m_ready   = (int'($urandom_range(0, 99)) < rdy_pct);
        enable    = en;
        empty     = (src_q.size() == 0) || (int'($urandom_range(0, 99)) < stall_pct);
        #1;
        occ = exp_q.size() - int'(inflight);
        chk("level", 32'(level), 32'(occ));
        chk("m_valid", 32'(m_valid), 32'(occ != 0));
        if (occ != 0) begin
            chk("m_data", 32'(m_data), 32'(exp_q[0]));
            chk("m_last", 32'(m_last), 32'(last_q[0]));
        end
        chk("pkt_count", 32'(pkt_count), 32'(pkts[15:0]));
        pop     = (occ != 0) && m_ready;
        exp_ren = enable && !empty && (occ + int'(inflight) - int'(pop) <= 1);
        chk("r_en", 32'(r_en), 32'(exp_ren));

        ren_cnt += int'(r_en);
        ren_run  = r_en ? ren_run + 1 : 0;
        if (ren_run > ren_max) ren_max = ren_run;
        if (r_en && first_ren < 0) first_ren = cyc;
        if (m_valid && first_vld < 0) first_vld = cyc;
        if (pop && m_last && first_last_pop < 0) first_last_pop = npop + 1;

        if (pop) begin
            if (last_q[0]) pkts++;
            void'(exp_q.pop_front());
            void'(last_q.pop_front());
            npop++;
        end
        if (exp_ren) begin
            rd_word = src_q.pop_front();
            exp_q.push_back(rd_word);
            last_q.push_back((rd_idx % PL) == PL - 1);
            rd_idx++;
        end
        inflight = exp_ren;
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge r_clk);
        #2 r_rst_n = 1'b0;
        #1;
        chk("rst_r_en", 32'(r_en), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_pkt_count", 32'(pkt_count), 32'd0);
        model_reset();
        repeat (2) @(negedge r_clk);
        enable  = 1'b0;
        r_rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        r_rst_n   = 1'b0;
        enable    = 1'b1;
        empty     = 1'b0;
        m_ready   = 1'b1;
        data_read = '0;
        do_reset();

        // Streaming two full packets
        for (int i = 0; i < 32; i++) src_q.push_back(DW'(i));
        clr_stats();
        repeat (36) step(100, 0, 1);
        chk("stream_ren_run", 32'(ren_max), 32'd32);
        chk("stream_latency", 32'(first_vld - first_ren), 32'd2);
        chk("stream_words", 32'(npop), 32'd32);
        chk("stream_pkts", 32'(pkt_count), 32'd2);

        // Back-pressure from the start, then release
        do_reset();
        for (int i = 0; i < 10; i++) src_q.push_back(DW'(i));
        clr_stats();
        repeat (6) step(0, 0, 1);
        chk("bp_ren_pulses", 32'(ren_cnt), 32'd2);
        chk("bp_level", 32'(level), 32'd2);
        chk("bp_data", 32'(m_data), 32'd0);
        repeat (15) step(100, 0, 1);
        chk("bp_words", 32'(npop), 32'd10);

        // Empty held high, then enable dropped mid-stream
        clr_stats();
        repeat (5) step(100, 100, 1);
        chk("empty_ren", 32'(ren_cnt), 32'd0);
        for (int i = 0; i < 20; i++) src_q.push_back(DW'(8'h40 + i));
        repeat (6) step(100, 0, 1);
        clr_stats();
        repeat (8) step(100, 0, 0);
        chk("dis_ren", 32'(ren_cnt), 32'd0);
        chk("dis_level", 32'(level), 32'd0);
        chk("dis_valid", 32'(m_valid), 32'd0);

        // Random back-pressure and FIFO stalls
        for (int i = 0; i < 500; i++) src_q.push_back(DW'($urandom));
        for (int c = 0; c < 8000 && (src_q.size() + exp_q.size()) != 0; c++)
            step(50, 30, 1);
        chk("rand_drained", 32'(src_q.size() + exp_q.size()), 32'd0);

        // Reset with five words captured and the buffer full
        do_reset();
        for (int i = 0; i < 40; i++) src_q.push_back(DW'(8'h80 + i));
        for (int c = 0; c < 20 && npop < 3; c++) step(100, 0, 1);
        repeat (2) step(0, 0, 1);
        chk("mid_level", 32'(level), 32'd2);
        do_reset();
        clr_stats();
        repeat (25) step(100, 0, 1);
        chk("mid_first_last", 32'(first_last_pop), 32'd16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
